// File: rtl/anita4_trig_pkg.sv
// Shared state encoding, default constants and index-width helper for the ANITA4 trigger path.
// The HOLDOFF state is only present when ANITA4_HOLDOFF_EN is defined.
package anita4_trig_pkg;
  localparam int DEF_LOST_W     = 16;
  localparam int DEF_HOLD_DELAY = 8;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLDING  = 2'd1,
`ifdef ANITA4_HOLDOFF_EN
    HOLDOFF  = 2'd3,
`endif
    DIGITIZE = 2'd2
  } bm_state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) w = i + 1;
    return w;
  endfunction
endpackage

// File: rtl/anita4_buffer_manager_if.sv
// Trigger-side / readout-side bundle of the buffer manager; holdoff_i exists only with ANITA4_HOLDOFF_EN.
interface anita4_buffer_manager_if #(
  parameter int NUM_BUFFERS = 4,
  parameter int NUM_SOURCES = 4,
  parameter int LOST_W      = anita4_trig_pkg::DEF_LOST_W
) ();
  import anita4_trig_pkg::*;
  localparam int BUF_W = clog2(NUM_BUFFERS);

  logic [NUM_SOURCES-1:0] trig_i;
  logic [NUM_SOURCES-1:0] trig_mask_i;
  logic                   clear_i;
  logic [BUF_W-1:0]       clear_buffer_i;
`ifdef ANITA4_HOLDOFF_EN
  logic [15:0]            holdoff_i;
`endif
  logic [NUM_BUFFERS-1:0] hold_o;
  logic                   digitize_o;
  logic [BUF_W-1:0]       digitize_buffer_o;
  logic [NUM_SOURCES-1:0] digitize_source_o;
  logic [NUM_BUFFERS-1:0] buffer_status_o;
  logic                   dead_o;
  logic [LOST_W-1:0]      lost_count_o;

  modport master (
`ifdef ANITA4_HOLDOFF_EN
    output holdoff_i,
`endif
    output trig_i, trig_mask_i, clear_i, clear_buffer_i,
    input  hold_o, digitize_o, digitize_buffer_o, digitize_source_o,
    input  buffer_status_o, dead_o, lost_count_o
  );

  modport slave (
`ifdef ANITA4_HOLDOFF_EN
    input  holdoff_i,
`endif
    input  trig_i, trig_mask_i, clear_i, clear_buffer_i,
    output hold_o, digitize_o, digitize_buffer_o, digitize_source_o,
    output buffer_status_o, dead_o, lost_count_o
  );
endinterface

// File: rtl/anita4_trig_edge.sv
// Rising-edge detector over the trigger sources; masked sources never produce an edge.
module anita4_trig_edge #(
  parameter int NUM_SOURCES = 4
) (
  input  logic                   clk250_i,
  input  logic                   rst_n_i,
  input  logic [NUM_SOURCES-1:0] trig_i,
  input  logic [NUM_SOURCES-1:0] trig_mask_i,
  output logic [NUM_SOURCES-1:0] trig_edge
);
  logic [NUM_SOURCES-1:0] trig_q;

  always_ff @(posedge clk250_i or negedge rst_n_i)
    if (!rst_n_i) trig_q <= '0;
    else          trig_q <= trig_i;

  assign trig_edge = trig_i & ~trig_q & trig_mask_i;
endmodule

// File: rtl/anita4_buffer_manager.sv
// Turns masked trigger edges into per-buffer HOLD plus a delayed digitize strobe and tracks occupancy.
// Optional post-digitize holdoff is enabled with ANITA4_HOLDOFF_EN.
module anita4_buffer_manager
  import anita4_trig_pkg::*;
#(
  parameter int NUM_BUFFERS = 4,
  parameter int NUM_SOURCES = 4,
  parameter int HOLD_DELAY  = DEF_HOLD_DELAY,
  parameter int LOST_W      = DEF_LOST_W
) (
  input logic                    clk250_i,
  input logic                    rst_n_i,
  anita4_buffer_manager_if.slave bus
);
  localparam int BUF_W = clog2(NUM_BUFFERS);

  logic [NUM_SOURCES-1:0] trig_edge;
  bm_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BUF_W-1:0]       wr_ptr_q, wr_ptr_d, buf_q, buf_d;
  logic [NUM_SOURCES-1:0] src_q, src_d;
  logic [NUM_BUFFERS-1:0] occ_q, occ_d;
  logic [LOST_W-1:0]      lost_q, lost_d;
  logic                   dead_q, dig_q;
  logic [BUF_W-1:0]       dig_buf_q;
  logic [NUM_SOURCES-1:0] dig_src_q;
  logic                   any_edge, accept;

  anita4_trig_edge #(.NUM_SOURCES(NUM_SOURCES)) u_edge (
    .clk250_i    (clk250_i),
    .rst_n_i     (rst_n_i),
    .trig_i      (bus.trig_i),
    .trig_mask_i (bus.trig_mask_i),
    .trig_edge   (trig_edge)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    buf_d    = buf_q;
    src_d    = src_q;
    lost_d   = lost_q;
    occ_d    = occ_q;
    // Clear lands before acceptance so a same-cycle trigger can reuse the freed buffer.
    if (bus.clear_i) occ_d[bus.clear_buffer_i] = 1'b0;
    any_edge = |trig_edge;
    accept   = (state_q == IDLE) && any_edge && !occ_d[wr_ptr_q];
    case (state_q)
      IDLE:
        if (accept) begin
          occ_d[wr_ptr_q] = 1'b1;
          src_d           = trig_edge;
          buf_d           = wr_ptr_q;
          cnt_d           = CNT_W'(HOLD_DELAY - 1);
          state_d         = HOLDING;
        end
      HOLDING:
        if (cnt_q == '0) state_d = DIGITIZE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      DIGITIZE: begin
        wr_ptr_d = wr_ptr_q + BUF_W'(1);
        state_d  = IDLE;
`ifdef ANITA4_HOLDOFF_EN
        if (bus.holdoff_i != 16'd0) begin
          cnt_d   = bus.holdoff_i - 16'd1;
          state_d = HOLDOFF;
        end
`endif
      end
`ifdef ANITA4_HOLDOFF_EN
      HOLDOFF:
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
`endif
      default: state_d = IDLE;
    endcase
    if (any_edge && !accept && lost_q != '1) lost_d = lost_q + LOST_W'(1);
  end

  always_ff @(posedge clk250_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      buf_q     <= '0;
      src_q     <= '0;
      occ_q     <= '0;
      lost_q    <= '0;
      dead_q    <= 1'b0;
      dig_q     <= 1'b0;
      dig_buf_q <= '0;
      dig_src_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      buf_q    <= buf_d;
      src_q    <= src_d;
      occ_q    <= occ_d;
      lost_q   <= lost_d;
      // Registered from next-state so the flags line up with the state they describe.
      dead_q   <= (state_d != IDLE) | occ_d[wr_ptr_d];
      dig_q    <= (state_d == DIGITIZE);
      if (state_d == DIGITIZE) begin
        dig_buf_q <= buf_d;
        dig_src_q <= src_d;
      end
    end

  assign bus.hold_o            = occ_q;
  assign bus.buffer_status_o   = occ_q;
  assign bus.digitize_o        = dig_q;
  assign bus.digitize_buffer_o = dig_buf_q;
  assign bus.digitize_source_o = dig_src_q;
  assign bus.dead_o            = dead_q;
  assign bus.lost_count_o      = lost_q;
endmodule
